// File: rtl/uart_bridge_ctrl.sv
// Round-robin write/read sequencer in front of the bridge's shared UART link.
// Each grant becomes one TX frame {mode, data, addr}; reads then wait for a one-byte reply.
module uart_bridge_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned START_GUARD    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_req,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  output logic                             wr_ack,
  input  logic                             rd_req,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic                             rd_ack,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  output logic                             rd_err,
  output logic [DATA_WIDTH+ADDR_WIDTH:0]   u_din,
  output logic                             u_en,
  input  logic                             u_tx_busy,
  input  logic                             u_rx_ready,
  input  logic [DATA_WIDTH-1:0]            u_dout,
  output logic                             busy
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GD_W = $clog2(START_GUARD + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [GD_W-1:0] GD_LAST = GD_W'(START_GUARD - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_TX, RD_WAIT} state_t;

  state_t          state;
  logic            op_wr;
  logic            last_wr;
  logic            tx_seen;
  logic [TO_W-1:0] to_cnt;
  logic [GD_W-1:0] gd_cnt;
  logic            pick_wr;
  logic            tx_done;

  // Write wins unless both are pending and write was granted last.
  assign pick_wr = wr_req && !(rd_req && last_wr);
  // Frame is finished once busy has risen and fallen, or busy never rose within the guard.
  assign tx_done = !u_tx_busy && (tx_seen || (gd_cnt == GD_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      wr_ack   <= 1'b0;
      rd_ack   <= 1'b0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
      u_din    <= '0;
      u_en     <= 1'b0;
      op_wr    <= 1'b0;
      last_wr  <= 1'b0;
      tx_seen  <= 1'b0;
      to_cnt   <= '0;
      gd_cnt   <= '0;
    end else begin
      wr_ack   <= 1'b0;
      rd_ack   <= 1'b0;
      u_en     <= 1'b0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_req || rd_req) begin
            op_wr   <= pick_wr;
            last_wr <= pick_wr;
            busy    <= 1'b1;
            state   <= ISSUE;
            if (pick_wr) begin
              u_din  <= {1'b1, wr_data, wr_addr};
              wr_ack <= 1'b1;
            end else begin
              u_din  <= {1'b0, {DATA_WIDTH{1'b0}}, rd_addr};
              rd_ack <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (!u_tx_busy) begin
            u_en    <= 1'b1;
            tx_seen <= 1'b0;
            gd_cnt  <= '0;
            state   <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (!tx_seen && u_tx_busy) begin
            tx_seen <= 1'b1;
          end else if (tx_done) begin
            if (op_wr) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              to_cnt <= '0;
              state  <= RD_WAIT;
            end
          end else if (!tx_seen) begin
            gd_cnt <= gd_cnt + GD_W'(1);
          end
        end
        RD_WAIT: begin
          // A byte arriving on the last cycle still counts as a good response.
          if (u_rx_ready) begin
            rd_data  <= u_dout;
            rd_valid <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (to_cnt == TO_LAST) begin
            rd_data  <= '0;
            rd_valid <= 1'b1;
            rd_err   <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_bridge_ctrl.md
Name: uart_bridge_ctrl

Overview:
Transaction sequencer and arbiter in front of the bus bridge's shared UART link. It accepts write and read requests from two requesters and grants them round-robin. Each granted request becomes one TX frame {mode, data, addr}, paced against the UART busy flag. For reads it then waits, with a timeout, for the one-byte UART RX response and returns it to the read requester.

Parameters:
DATA_WIDTH, 8, data field width and RX response width
ADDR_WIDTH, 12, address field width
TIMEOUT_CYCLES, 1000000, clk cycles RD_WAIT waits for u_rx_ready before flagging an error
START_GUARD, 4, max cycles after u_en to see u_tx_busy rise before the frame is treated as sent

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
wr_req  in  1  write request, level; held until wr_ack
wr_addr  in  ADDR_WIDTH  write address, valid while wr_req
wr_data  in  DATA_WIDTH  write data, valid while wr_req
wr_ack  out  1  one-cycle pulse: write captured
rd_req  in  1  read request, level; held until rd_ack
rd_addr  in  ADDR_WIDTH  read address, valid while rd_req
rd_ack  out  1  one-cycle pulse: read captured
rd_data  out  DATA_WIDTH  read response, valid when rd_valid
rd_valid  out  1  one-cycle pulse: read complete
rd_err  out  1  qualifies rd_valid: 1 = timeout
u_din  out  DATA_WIDTH+ADDR_WIDTH+1  TX frame to UART
u_en  out  1  one-cycle TX start strobe
u_tx_busy  in  1  UART transmitter busy
u_rx_ready  in  1  UART RX byte-valid pulse
u_dout  in  DATA_WIDTH  UART RX byte
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst high at a clk edge) forces: state IDLE; all outputs 0; u_din 0; counters 0; rr pointer set so write wins the first tie.
- Reset mid-operation aborts the current transaction. No ack or rd_valid is produced for it.
- Frame layout: u_din = {mode, data, addr}. addr is bits [ADDR_WIDTH-1:0]. MSB is mode: 1 = write, 0 = read. Read frames carry data field = 0.
- u_din is registered at grant and held stable until the next grant.
- States: IDLE, ISSUE, WAIT_TX, RD_WAIT.
- IDLE with no request: stay in IDLE.
- IDLE with one request: grant it.
- IDLE with both requests: grant the one not granted last, then flip the rr pointer.
- At grant: load u_din; pulse wr_ack or rd_ack in the same cycle as the load; record the op type; next state ISSUE. Zero-cycle arbitration latency: grant in the first cycle the request is seen in IDLE.
- ISSUE: if u_tx_busy = 0, pulse u_en for exactly 1 cycle and go to WAIT_TX; else stay in ISSUE.
- WAIT_TX: wait for u_tx_busy to rise, then to fall.
- WAIT_TX guard: if u_tx_busy never rises within START_GUARD cycles of u_en, treat the frame as sent.
- WAIT_TX exit: on write go to IDLE; on read clear the timeout counter and go to RD_WAIT.
- RD_WAIT on u_rx_ready: rd_data <= u_dout; rd_valid = 1 and rd_err = 0 for 1 cycle; go to IDLE.
- RD_WAIT timeout: when the counter reaches TIMEOUT_CYCLES-1 without u_rx_ready, rd_data <= 0; rd_valid = 1 and rd_err = 1 for 1 cycle; go to IDLE.
- If u_rx_ready and timeout coincide, data wins (rd_err = 0).
- u_rx_ready outside RD_WAIT is ignored and the byte is dropped.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- A request held high after its ack is a new request. It is eligible at the next IDLE and is subject to round-robin.
- Only one transaction is outstanding at a time.
- rd_data holds its value between responses.

Test Plan:
- Single write: rst 2 cycles; wr_req with addr 0x123, data 0xA5; u_tx_busy idle -> wr_ack next edge; u_en 1 cycle; u_din = 0x1A5123; no rd_valid.
- Read OK: rd_addr 0x0FF; model asserts u_tx_busy 3 cycles after u_en for 20 cycles, then u_rx_ready with u_dout 0x3C 10 cycles later -> u_din = 0x0000FF; rd_valid 1 cycle; rd_data 0x3C; rd_err 0.
- Read timeout (TIMEOUT_CYCLES = 16): no u_rx_ready -> rd_valid + rd_err exactly 16 cycles after RD_WAIT entry; rd_data 0; back to IDLE with busy 0.
- Arbitration: wr_req and rd_req both held for 4 transactions -> grant order W, R, W, R; each ack a single pulse; no u_en while u_tx_busy is 1.
- Busy gating and guard: u_tx_busy high at grant -> u_en held off until it falls. Second case: u_tx_busy never asserted -> WAIT_TX exits after START_GUARD cycles.
- Reset mid-read: rst asserted in RD_WAIT, then u_rx_ready arrives -> all outputs 0; no rd_valid; next wr_req serviced normally.
